conv_row_sequencer: RTL and testbench
=====================================

Name: conv_row_sequencer

Overview:
Layer-level controller for the 3x3 convolve engine. It walks a feature map of up to 63 rows one output row at a time. For each output row it fills the three line buffers with the correct source rows, pulses the engine start and waits for engine done. It then advances the window by the stride, steering each output row into alternating destination banks (ping-pong) so downstream pooling can consume one row while the next is computed.

Parameters:
ROW_W, 6, width of row indices and the fm_rows input
ADDR_W, 5, width of the engine destination address; the MSB is used as the bank bit

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
layer_start  in  1  request to start a layer; sampled only in IDLE
abort  in  1  cancel the layer in progress; returns to IDLE
cfg_stride  in  2  stride; only 1 and 2 are legal
cfg_fm_rows  in  ROW_W  input feature-map height; must be >= 3
cfg_dest_base  in  ADDR_W  destination base address; bit ADDR_W-1 is ignored
lb_load_req  out  1  line-buffer row-load request; held until acknowledged
lb_row_addr  out  ROW_W  source row to load; stable while lb_load_req is high
lb_load_ack  in  1  line buffer has accepted the row
conv_start  out  1  one-cycle start pulse to the engine
conv_stride  out  2  latched stride, driven to the engine
conv_dest_addr  out  ADDR_W  {bank, cfg_dest_base[ADDR_W-2:0]}
conv_done  in  1  engine done; sampled only in WAIT_DONE
row_valid  out  1  one-cycle pulse when an output row is complete
out_row_idx  out  ROW_W  index of the current output row
row_bank  out  1  bank that holds the completed row
busy  out  1  high in every state except IDLE
layer_done  out  1  one-cycle pulse when the last row completes
cfg_err  out  1  one-cycle pulse when a start request has an illegal configuration

Behaviour:
- Clocking and reset: single clock, all state updates on the rising edge. Reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0 (lb_row_addr, conv_stride, conv_dest_addr and out_row_idx included). Internal counters are 0 and bank=0.
- States: IDLE, PRELOAD, START, WAIT_DONE, ADVANCE, FINISH.
- IDLE:
  - On layer_start with cfg_stride in {1,2} and cfg_fm_rows>=3: latch stride, rows and dest base; compute n_out=((rows-3)>>(stride-1))+1; set top=0, out_row_idx=0, bank=0, load_cnt=0; go to PRELOAD.
  - On layer_start with an illegal configuration: cfg_err=1 for one cycle, stay in IDLE.
- Load handshake (PRELOAD and ADVANCE):
  - lb_load_req rises the cycle after the state is entered, with lb_row_addr valid in the same cycle.
  - The request is accepted on the cycle where req and ack are both high.
  - The next cycle, req drops and load_cnt increments.
  - The next request, if any, rises the cycle after that: one idle cycle between rows.
  - ack while req is low is ignored.
- PRELOAD: loads rows top, top+1, top+2 in order. After the third acceptance, go to START.
- START: conv_start=1 for exactly one cycle, with conv_dest_addr={bank, base}. Go to WAIT_DONE.
- WAIT_DONE: wait for conv_done=1. On that cycle:
  - row_valid=1, with row_bank=bank and out_row_idx unchanged.
  - If out_row_idx==n_out-1, go to FINISH.
  - Otherwise out_row_idx+=1, bank toggles, top+=stride, go to ADVANCE.
- ADVANCE: loads the stride new rows: top+3-stride up to top+2 of the new window. Then go to START.
- FINISH: layer_done=1 for one cycle, then IDLE.
- Ignored inputs:
  - conv_done outside WAIT_DONE.
  - layer_start outside IDLE.
- abort (highest priority after rst), from any non-IDLE state:
  - Next state is IDLE.
  - lb_load_req, conv_start and row_valid are forced to 0 in the cycle abort is sampled.
  - No layer_done.
  - An abort asserted together with conv_done suppresses row_valid.
- Load count per layer: 3+(n_out-1)*stride.
  - fm_rows=28, stride 1: 28 loads, 26 output rows.
  - fm_rows=28, stride 2: 27 loads, 13 output rows; row 27 is never loaded.
- Arithmetic: all row arithmetic is unsigned on ROW_W bits. top+2 is never greater than rows-1 by construction.
- Minimum configuration: fm_rows=3 gives n_out=1, so the sequence is PRELOAD, START, WAIT_DONE, FINISH with no ADVANCE.

Test Plan:
- Stride 1, fm_rows=28, base=5, ack one cycle after each req, done 12 cycles after start:
  - exactly 28 acceptances with lb_row_addr 0..27 in order and 26 conv_start pulses;
  - conv_dest_addr alternates 5, 21, 5, ...;
  - row_valid out_row_idx runs 0..25, then one layer_done.
- Stride 2, fm_rows=28: 27 loads; after the preload of 0,1,2, the pairs are (3,4), (5,6) ... (25,26); 13 row_valid pulses; layer_done after idx 12.
- Illegal configurations:
  - layer_start with cfg_stride=3: cfg_err pulses, busy stays 0, no req.
  - cfg_fm_rows=2: cfg_err pulses, busy stays 0, no req.
- Backpressure: hold ack low for 10 cycles on row 1 → req and lb_row_addr=1 stay stable the whole time, and no conv_start occurs before the third acceptance.
- Abort and spurious inputs:
  - Assert abort in WAIT_DONE on row 4, together with conv_done → no row_valid, no layer_done; IDLE next cycle with busy=0.
  - A new layer_start then restarts from row 0 with bank 0.
  - conv_done pulses during PRELOAD are ignored.
- fm_rows=3 minimum layer: 3 loads, 1 start, 1 row_valid (idx 0, bank 0), then layer_done.
- Mid-operation reset: assert rst during ADVANCE → all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/conv_row_sequencer_if.sv
// Handshake bundle between the row sequencer (master), the line buffers and the 3x3 engine.
interface conv_row_sequencer_if #(
  parameter int ROW_W  = 6,
  parameter int ADDR_W = 5
);
  logic              lb_load_req;
  logic [ROW_W-1:0]  lb_row_addr;
  logic              lb_load_ack;
  logic              conv_start;
  logic [1:0]        conv_stride;
  logic [ADDR_W-1:0] conv_dest_addr;
  logic              conv_done;
  logic              row_valid;
  logic [ROW_W-1:0]  out_row_idx;
  logic              row_bank;

  modport master (
    output lb_load_req, lb_row_addr, conv_start, conv_stride, conv_dest_addr,
           row_valid, out_row_idx, row_bank,
    input  lb_load_ack, conv_done
  );

  modport slave (
    input  lb_load_req, lb_row_addr, conv_start, conv_stride, conv_dest_addr,
           row_valid, out_row_idx, row_bank,
    output lb_load_ack, conv_done
  );
endinterface

// File: rtl/conv_row_sequencer.sv
// Layer controller for the 3x3 convolve engine: fills line buffers per output row,
// launches the engine and ping-pongs finished rows between two destination banks.
module conv_row_sequencer #(
  parameter int ROW_W  = 6,
  parameter int ADDR_W = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_layer_start,
  input  logic                     i_abort,
  input  logic [1:0]               i_cfg_stride,
  input  logic [ROW_W-1:0]         i_cfg_fm_rows,
  input  logic [ADDR_W-1:0]        i_cfg_dest_base,
  conv_row_sequencer_if.master     bus,
  output logic                     o_busy,
  output logic                     o_layer_done,
  output logic                     o_cfg_err
);
  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_START, S_WAIT_DONE, S_ADVANCE, S_FINISH
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_req;
  logic [ROW_W-1:0]  r_addr, r_top, r_row_idx, r_last;
  logic [1:0]        r_stride, r_phase_cnt;
  logic [ADDR_W-2:0] r_base;
  logic              r_bank;

  logic              w_cfg_ok, w_load_state, w_accept, w_load_last, w_abort, w_kill;
  logic [1:0]        w_need;
  logic [ROW_W-1:0]  w_win_base, w_last_calc;
  logic              w_unused_base_msb;

  // The bank bit comes from the ping-pong toggle, never from the configured base.
  assign w_unused_base_msb = i_cfg_dest_base[ADDR_W-1];

  assign w_cfg_ok     = (i_cfg_stride == 2'd1 || i_cfg_stride == 2'd2) &&
                        (i_cfg_fm_rows >= ROW_W'(3));
  assign w_last_calc  = (i_cfg_fm_rows - ROW_W'(3)) >> (i_cfg_stride - 2'd1);
  assign w_load_state = (r_state == S_PRELOAD) || (r_state == S_ADVANCE);
  assign w_need       = (r_state == S_PRELOAD) ? 2'd3 : r_stride;
  assign w_accept     = w_load_state && r_req && bus.lb_load_ack;
  assign w_load_last  = w_accept && (r_phase_cnt == w_need - 2'd1);
  // After a window move only the rows not already held by the buffers are fetched.
  assign w_win_base   = (r_state == S_PRELOAD) ? r_top
                                               : r_top + ROW_W'(3) - ROW_W'(r_stride);
  assign w_abort      = i_abort && (r_state != S_IDLE);
  assign w_kill       = i_rst || w_abort;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:               if (i_layer_start && w_cfg_ok) w_state_nxt = S_PRELOAD;
      S_PRELOAD, S_ADVANCE: if (w_load_last) w_state_nxt = S_START;
      S_START:              w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE:          if (bus.conv_done)
                              w_state_nxt = (r_row_idx == r_last) ? S_FINISH : S_ADVANCE;
      S_FINISH:             w_state_nxt = S_IDLE;
      default:              w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_top       <= '0;
      r_row_idx   <= '0;
      r_last      <= '0;
      r_stride    <= '0;
      r_phase_cnt <= '0;
      r_base      <= '0;
      r_bank      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_abort) begin
        r_req <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (i_layer_start && w_cfg_ok) begin
            r_stride    <= i_cfg_stride;
            r_base      <= i_cfg_dest_base[ADDR_W-2:0];
            r_last      <= w_last_calc;
            r_top       <= '0;
            r_row_idx   <= '0;
            r_bank      <= 1'b0;
            r_phase_cnt <= '0;
          end
          // Request rises one cycle after entry or after the previous acceptance.
          S_PRELOAD, S_ADVANCE: begin
            if (w_accept) begin
              r_req       <= 1'b0;
              r_phase_cnt <= w_load_last ? 2'd0 : r_phase_cnt + 2'd1;
            end else if (!r_req) begin
              r_req  <= 1'b1;
              r_addr <= w_win_base + ROW_W'(r_phase_cnt);
            end
          end
          S_WAIT_DONE: if (bus.conv_done && r_row_idx != r_last) begin
            r_row_idx <= r_row_idx + ROW_W'(1);
            r_bank    <= ~r_bank;
            r_top     <= r_top + ROW_W'(r_stride);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.lb_load_req    = r_req && !w_kill;
  assign bus.lb_row_addr    = r_addr;
  assign bus.conv_start     = (r_state == S_START) && !w_kill;
  assign bus.conv_stride    = r_stride;
  assign bus.conv_dest_addr = {r_bank, r_base};
  assign bus.row_valid      = (r_state == S_WAIT_DONE) && bus.conv_done && !w_kill;
  assign bus.out_row_idx    = r_row_idx;
  assign bus.row_bank       = r_bank;
  assign o_busy             = (r_state != S_IDLE);
  assign o_layer_done       = (r_state == S_FINISH) && !w_kill;
  assign o_cfg_err          = (r_state == S_IDLE) && i_layer_start && !w_cfg_ok && !i_rst;
endmodule

// File: tb/tb_conv_row_sequencer.sv
// Bench for conv_row_sequencer: vector table, hand-built corner sequences and random
// layers, all checked against a window-level model of which rows/banks a layer must produce.
module tb_conv_row_sequencer;
  localparam int ROW_W  = 6;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0, rst = 1'b1, layer_start = 1'b0, abort = 1'b0;
  logic [1:0]        cfg_stride = 2'd1;
  logic [ROW_W-1:0]  cfg_fm_rows = ROW_W'(3);
  logic [ADDR_W-1:0] cfg_dest_base = '0;
  logic              busy, layer_done, cfg_err;

  conv_row_sequencer_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

  conv_row_sequencer #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_layer_start(layer_start), .i_abort(abort),
    .i_cfg_stride(cfg_stride), .i_cfg_fm_rows(cfg_fm_rows), .i_cfg_dest_base(cfg_dest_base),
    .bus(bus), .o_busy(busy), .o_layer_done(layer_done), .o_cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Line-buffer / engine responder settings
  int   ack_dly = 1, done_dly = 12, hold_row = -1, hold_cycles = 0;
  bit   ack_rand = 0, done_rand = 0, spur = 0;
  logic force_done = 1'b0, auto_done = 1'b0;
  assign bus.conv_done = auto_done | force_done;

  initial begin
    int age, cur, held, cnt;
    age = 0; cur = 0; held = 0; cnt = 0;
    bus.lb_load_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.lb_load_req) begin
        if (int'(bus.lb_row_addr) == hold_row && held < hold_cycles) begin
          bus.lb_load_ack = 1'b0; held++;
        end else if (age >= cur) bus.lb_load_ack = 1'b1;
        else begin bus.lb_load_ack = 1'b0; age++; end
      end else begin
        bus.lb_load_ack = spur && ($urandom_range(0, 3) == 0);
        age = 0; held = 0;
        cur = ack_rand ? int'($urandom_range(0, 3)) : ack_dly;
      end
      auto_done = 1'b0;
      if (cnt > 0) begin cnt--; if (cnt == 0) auto_done = 1'b1; end
      if (bus.conv_start) cnt = done_rand ? int'($urandom_range(1, 15)) : done_dly;
      if (spur && bus.lb_load_req && $urandom_range(0, 3) == 0) auto_done = 1'b1;
    end
  end

  // Monitor: records observed events mid-cycle
  int   obs_load[$], obs_dest[$], obs_row[$];
  int   n_done = 0, n_err = 0, n_busy = 0, n_req = 0, viol = 0, early = 0;
  int   layer_loads = 0, cur_nack = 0, max_nack = 0;
  logic p_req = 1'b0, p_acc = 1'b0;
  logic [ROW_W-1:0] p_addr = '0;

  initial forever begin
    @(negedge clk);
    if (p_req && !p_acc && !abort && !rst &&
        (!bus.lb_load_req || bus.lb_row_addr != p_addr)) viol++;
    if (layer_start && !busy) layer_loads = 0;
    if (bus.lb_load_req) n_req++;
    if (bus.lb_load_req && bus.lb_load_ack) begin
      obs_load.push_back(int'(bus.lb_row_addr)); layer_loads++;
    end
    if (bus.conv_start) begin
      obs_dest.push_back(int'(bus.conv_dest_addr));
      if (layer_loads < 3) early++;
    end
    if (bus.row_valid) obs_row.push_back(int'(bus.out_row_idx) * 2 + int'(bus.row_bank));
    if (layer_done) n_done++;
    if (cfg_err) n_err++;
    if (busy) n_busy++;
    if (bus.lb_load_req && !bus.lb_load_ack) cur_nack++; else cur_nack = 0;
    if (cur_nack > max_nack) max_nack = cur_nack;
    p_req = bus.lb_load_req; p_acc = bus.lb_load_req && bus.lb_load_ack;
    p_addr = bus.lb_row_addr;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: a layer is a list of windows; each window names its new rows, bank and slot.
  int exp_load[$], exp_dest[$], exp_row[$];
  function automatic void build_model(int s, int rows, int base);
    int n_out;
    n_out = (rows - 3) / s + 1;
    exp_load.delete(); exp_dest.delete(); exp_row.delete();
    for (int r = 0; r < n_out; r++) begin
      int top, first;
      top   = r * s;
      first = (r == 0) ? top : top + 3 - s;
      for (int k = first; k <= top + 2; k++) exp_load.push_back(k);
      exp_dest.push_back((base % 16) + 16 * (r % 2));
      exp_row.push_back(r * 2 + r % 2);
    end
  endfunction

  function automatic int first_bad(int obs[$], int off, int expq[$]);
    for (int i = 0; i < expq.size(); i++) begin
      if (off + i >= obs.size()) return i;
      if (obs[off + i] != expq[i]) return i;
    end
    if (obs.size() - off != expq.size()) return expq.size();
    return -1;
  endfunction

  function automatic int outs();
    return int'({bus.lb_load_req, bus.lb_row_addr, bus.conv_start, bus.conv_stride,
                 bus.conv_dest_addr, bus.row_valid, bus.out_row_idx, bus.row_bank,
                 busy, layer_done, cfg_err});
  endfunction

  task automatic pulse_start(int s, int rows, int base);
    cfg_stride = 2'(s); cfg_fm_rows = ROW_W'(rows); cfg_dest_base = ADDR_W'(base);
    @(posedge clk); #1 layer_start = 1'b1;
    @(posedge clk); #1 layer_start = 1'b0;
  endtask

  task automatic run_layer(string tag, int s, int rows, int base, int exp_loads, int exp_rows);
    int l0, d0, r0, nd, ne, nb, nq, v0, e0, c;
    bit bad;
    l0 = obs_load.size(); d0 = obs_dest.size(); r0 = obs_row.size();
    nd = n_done; ne = n_err; nb = n_busy; nq = n_req; v0 = viol; e0 = early; c = 0;
    bad = !(s == 1 || s == 2) || rows < 3;
    pulse_start(s, rows, base);
    while (n_done == nd && n_err == ne && c < 6000) begin @(posedge clk); #1; c++; end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "/finished"}, int'(c < 6000), 1);
    if (bad) begin
      chk({tag, "/cfg_err"}, n_err - ne, 1);
      chk({tag, "/no_req"}, n_req - nq, 0);
      chk({tag, "/no_busy"}, n_busy - nb, 0);
    end else begin
      build_model(s, rows, base);
      if (exp_loads >= 0) begin
        chk({tag, "/loads"}, obs_load.size() - l0, exp_loads);
        chk({tag, "/rows"}, obs_row.size() - r0, exp_rows);
      end
      chk({tag, "/load_seq"}, first_bad(obs_load, l0, exp_load), -1);
      chk({tag, "/dest_seq"}, first_bad(obs_dest, d0, exp_dest), -1);
      chk({tag, "/row_seq"}, first_bad(obs_row, r0, exp_row), -1);
      chk({tag, "/layer_done"}, n_done - nd, 1);
      chk({tag, "/no_cfg_err"}, n_err - ne, 0);
      chk({tag, "/req_stable"}, viol - v0, 0);
      chk({tag, "/start_after_preload"}, early - e0, 0);
      chk({tag, "/idle_after"}, int'(busy), 0);
    end
  endtask

  typedef struct { int s; int rows; int base; int ack_d; int done_d; int exp_loads; int exp_rows; } vec_t;
  vec_t vecs[10];

  initial begin
    int c, to_err, r0, d0, nd;
    vecs[0] = '{1, 28, 5, 1, 12, 28, 26};
    vecs[1] = '{2, 28, 5, 1, 12, 27, 13};
    vecs[2] = '{3, 28, 5, 1, 12, 0, 0};
    vecs[3] = '{1, 2, 5, 1, 12, 0, 0};
    vecs[4] = '{1, 3, 7, 0, 3, 3, 1};
    vecs[5] = '{2, 3, 2, 2, 5, 3, 1};
    vecs[6] = '{2, 8, 31, 0, 2, 7, 3};
    vecs[7] = '{0, 10, 1, 0, 2, 0, 0};
    vecs[8] = '{1, 63, 0, 0, 1, 63, 61};
    vecs[9] = '{2, 63, 17, 1, 6, 63, 31};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("reset_outputs", outs(), 0);

    foreach (vecs[i]) begin
      ack_dly = vecs[i].ack_d; done_dly = vecs[i].done_d;
      run_layer($sformatf("vec%0d", i), vecs[i].s, vecs[i].rows, vecs[i].base,
                vecs[i].exp_loads, vecs[i].exp_rows);
    end

    // Backpressure: ack withheld for 10 cycles on row 1
    ack_dly = 0; done_dly = 4; hold_row = 1; hold_cycles = 10;
    run_layer("backpressure", 1, 5, 9, 5, 3);
    chk("backpressure/held_cycles", max_nack, 10);
    hold_cycles = 0; hold_row = -1;

    // Abort together with conv_done while waiting on row 4
    done_dly = 0; spur = 1; to_err = 0;
    r0 = obs_row.size(); d0 = obs_dest.size(); nd = n_done;
    pulse_start(1, 28, 5);
    for (int k = 0; k < 5; k++) begin
      c = 0;
      while (obs_dest.size() < d0 + k + 1 && c < 2000) begin @(posedge clk); #1; c++; end
      if (c >= 2000) to_err++;
      repeat (2) @(posedge clk);
      #1;
      if (k < 4) begin force_done = 1'b1; @(posedge clk); #1 force_done = 1'b0; end
    end
    chk("abort/reached_row4", to_err, 0);
    force_done = 1'b1; abort = 1'b1;
    #2 chk("abort/row_valid_gated", int'(bus.row_valid), 0);
    @(posedge clk); #1 force_done = 1'b0; abort = 1'b0;
    #1 chk("abort/idle_next", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort/rows_before", obs_row.size() - r0, 4);
    chk("abort/no_layer_done", n_done - nd, 0);
    done_dly = 3;
    run_layer("restart", 1, 5, 3, 5, 3);

    // Reset while loading the second window
    spur = 0; ack_dly = 1; done_dly = 4; to_err = 0; r0 = obs_row.size();
    pulse_start(1, 10, 9);
    c = 0;
    while (obs_row.size() == r0 && c < 2000) begin @(posedge clk); #1; c++; end
    while (!bus.lb_load_req && c < 2000) begin @(posedge clk); #1; c++; end
    chk("midreset/reached_advance", int'(c < 2000), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("midreset/outputs_zero", outs(), 0);
    @(posedge clk); #1 chk("midreset/stays_idle", int'(busy), 0);

    // Random layers with random handshake timing and spurious ack/done
    ack_rand = 1; done_rand = 1; spur = 1;
    for (int i = 0; i < 16; i++) begin
      int s, rows, base, sel;
      s    = int'($urandom_range(1, 2));
      rows = int'($urandom_range(3, 63));
      base = int'($urandom_range(0, 31));
      sel  = int'($urandom_range(0, 9));
      if (sel == 0) s = ($urandom_range(0, 1) == 1) ? 3 : 0;
      if (sel == 1) rows = int'($urandom_range(0, 2));
      run_layer($sformatf("rand%0d", i), s, rows, base, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
